mix_columns_iter: RTL and testbench

Iterative AES MixColumns / InvMixColumns stage sitting directly downstream of the ShiftRows stage in the round datapath. It consumes the 128-bit shifted state and processes `COLS_PER_CYCLE` columns per clock. It produces the mixed state with a one-cycle `success` pulse. A `lastRound` bypass passes the state through unchanged, because the final AES round skips MixColumns.

---
 rtl/mix_columns_iter.sv | 159 +++++++++++++++
 tb/tb_mix_columns_iter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns / InvMixColumns stage with a last-round bypass.
// The stage takes COLS_PER_CYCLE columns per falling clock edge. It holds
// the result on valueMixed and pulses success for one cycle when a block
// completes. Byte 0 is the leftmost (most significant) byte of the 128-bit
// state, and column c is made of bytes 4c..4c+3.

// Combinational mixer for one 32-bit column: forward or inverse matrix.
module mix_column (
    input  logic [31:0] col_in,
    input  logic        inverse,
    output logic [31:0] col_out
);

    // Multiply by 2 in GF(2^8) using the AES reduction polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    logic [7:0] a  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];

    // The doubled, quadrupled and octupled values of each byte are the only
    // products needed: 3, 9, 0b, 0d and 0e are XOR combinations of them.
    for (genvar r = 0; r < 4; r++) begin : g_prep
        assign a[r]  = col_in[31-8*r -: 8];
        assign x2[r] = xtime(a[r]);
        assign x4[r] = xtime(x2[r]);
        assign x8[r] = xtime(x4[r]);
    end

    // Apply the rotated coefficient row for each output byte.
    always_comb begin
        // NOTE: every variable written in a combinational block is given a
        // default first, so that no path through the block can infer a latch.
        col_out = '0;
        for (int r = 0; r < 4; r++) begin
            if (inverse) begin
                col_out[31-8*r -: 8] = (x8[r] ^ x4[r] ^ x2[r])
                                     ^ (x8[(r+1)%4] ^ x2[(r+1)%4] ^ a[(r+1)%4])
                                     ^ (x8[(r+2)%4] ^ x4[(r+2)%4] ^ a[(r+2)%4])
                                     ^ (x8[(r+3)%4] ^ a[(r+3)%4]);
            end else begin
                col_out[31-8*r -: 8] = x2[r]
                                     ^ (x2[(r+1)%4] ^ a[(r+1)%4])
                                     ^ a[(r+2)%4]
                                     ^ a[(r+3)%4];
            end
        end
    end

endmodule

// Top level: control FSM, working register, and COLS_PER_CYCLE mixer slots.
module mix_columns_iter #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         mixEnable,
    input  logic         inverse,
    input  logic         lastRound,
    input  logic [127:0] value,
    output logic [127:0] valueMixed,
    output logic         success,
    output logic         busy
);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_param
        $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    // The counter wraps naturally. With four columns per cycle the step is
    // 0, so the counter stays at 0 and the first compute edge is the last one.
    localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

    typedef enum logic [1:0] {IDLE, COMPUTE, PASS} state_t;

    state_t       state;
    logic [1:0]   col;
    logic [127:0] work;
    logic         inv_q;
    logic [127:0] work_next;

    logic [1:0]  slot_idx [COLS_PER_CYCLE];
    logic [31:0] slot_in  [COLS_PER_CYCLE];
    logic [31:0] slot_out [COLS_PER_CYCLE];

    // One mixer per slot. Slot k works on column col+k of the working register.
    for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_slot
        assign slot_idx[k] = col + 2'(k);
        assign slot_in[k]  = work[32*(3-slot_idx[k]) +: 32];

        mix_column u_mix (
            .col_in  (slot_in[k]),
            .inverse (inv_q),
            .col_out (slot_out[k])
        );
    end

    // Working register with this cycle's columns replaced by their mixed values.
    always_comb begin
        work_next = work;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            work_next[32*(3-slot_idx[k]) +: 32] = slot_out[k];
        end
    end

    // Control FSM and all state. Updates happen on the falling edge.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            col        <= '0;
            // NOTE: the working register is a plain flop bank rather than a
            // memory, so clearing it on reset is cheap. Clearing it also means
            // no column of an aborted block can reappear after reset.
            work       <= '0;
            inv_q      <= 1'b0;
            valueMixed <= '0;
            success    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every branch here reads the pre-edge values of the registers.
            case (state)
                IDLE: begin
                    success <= 1'b0;
                    if (mixEnable) begin
                        work  <= value;
                        inv_q <= inverse;
                        col   <= '0;
                        busy  <= 1'b1;
                        state <= lastRound ? PASS : COMPUTE;
                    end
                end
                COMPUTE: begin
                    work <= work_next;
                    col  <= col + STEP;
                    if (col == LAST_COL) begin
                        valueMixed <= work_next;
                        success    <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                PASS: begin
                    valueMixed <= work;
                    success    <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mix_columns_iter.sv
// Bench for mix_columns_iter. It runs three instances side by side, with 1,
// 2 and 4 columns per cycle. Results are compared against a reference model
// that computes the AES column matrix product with a generic GF(2^8) multiply.
module tb_mix_columns_iter;

    logic clk = 1'b0;
    logic reset;

    logic         mix_enable [3];
    logic         inverse    [3];
    logic         last_round [3];
    logic [127:0] value      [3];
    logic [127:0] value_mixed[3];
    logic         success    [3];
    logic         busy       [3];

    logic [127:0] last_res [3];

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    mix_columns_iter #(.COLS_PER_CYCLE(1)) dut_c1 (
        .clk(clk), .reset(reset), .mixEnable(mix_enable[0]), .inverse(inverse[0]),
        .lastRound(last_round[0]), .value(value[0]), .valueMixed(value_mixed[0]),
        .success(success[0]), .busy(busy[0]));

    mix_columns_iter #(.COLS_PER_CYCLE(2)) dut_c2 (
        .clk(clk), .reset(reset), .mixEnable(mix_enable[1]), .inverse(inverse[1]),
        .lastRound(last_round[1]), .value(value[1]), .valueMixed(value_mixed[1]),
        .success(success[1]), .busy(busy[1]));

    mix_columns_iter #(.COLS_PER_CYCLE(4)) dut_c4 (
        .clk(clk), .reset(reset), .mixEnable(mix_enable[2]), .inverse(inverse[2]),
        .lastRound(last_round[2]), .value(value[2]), .valueMixed(value_mixed[2]),
        .success(success[2]), .busy(busy[2]));

    // Generic shift-and-add GF(2^8) multiply.
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic       carry;
        a = a_in; b = b_in; p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            carry = a[7];
            a = a << 1;
            if (carry) a = a ^ 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    // Matrix entry at distance d to the right of the diagonal.
    function automatic logic [7:0] coef(input logic inv, input int d);
        case (d)
            0:       return inv ? 8'h0e : 8'h02;
            1:       return inv ? 8'h0b : 8'h03;
            2:       return inv ? 8'h0d : 8'h01;
            default: return inv ? 8'h09 : 8'h01;
        endcase
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv, input logic last);
        logic [127:0] res;
        logic [7:0]   acc;
        if (last) return s;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = '0;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(coef(inv, (j - r + 4) % 4), s[127-8*(4*c+j) -: 8]);
                res[127-8*(4*c+r) -: 8] = acc;
            end
        end
        return res;
    endfunction

    function automatic int latency(input int idx);
        return (idx == 0) ? 4 : (idx == 1) ? 2 : 1;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete operation on instance idx, with cycle-by-cycle checks of
    // busy, success and the held output.
    task automatic run_op(input int idx, input logic [127:0] v, input logic inv,
                          input logic last, input string tag);
        logic [127:0] expected;
        int           n;
        expected = ref_mix(v, inv, last);
        n = last ? 1 : latency(idx);
        @(posedge clk);
        mix_enable[idx] = 1'b1; inverse[idx] = inv; last_round[idx] = last; value[idx] = v;
        @(negedge clk);                                  // E0
        @(posedge clk);
        check({tag, "_busy_e0"}, 128'(busy[idx]), 128'(1'b1));
        check({tag, "_succ_e0"}, 128'(success[idx]), 128'(1'b0));
        // Captured inputs must not be re-sampled.
        mix_enable[idx] = 1'b0; inverse[idx] = ~inv; last_round[idx] = ~last; value[idx] = rnd128();
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);                              // Ek
            @(posedge clk);
            if (k < n) begin
                check({tag, "_busy_mid"}, 128'(busy[idx]), 128'(1'b1));
                check({tag, "_succ_mid"}, 128'(success[idx]), 128'(1'b0));
                check({tag, "_hold_mid"}, value_mixed[idx], last_res[idx]);
            end else begin
                check({tag, "_succ_done"}, 128'(success[idx]), 128'(1'b1));
                check({tag, "_busy_done"}, 128'(busy[idx]), 128'(1'b0));
                check({tag, "_result"}, value_mixed[idx], expected);
            end
        end
        last_res[idx] = expected;
        @(negedge clk);                                  // EN+1
        @(posedge clk);
        check({tag, "_succ_clear"}, 128'(success[idx]), 128'(1'b0));
        check({tag, "_hold_after"}, value_mixed[idx], last_res[idx]);
    endtask

    initial begin
        logic [127:0] a_blk, b_blk, v;
        int           succ_count;

        for (int i = 0; i < 3; i++) begin
            mix_enable[i] = 1'b0; inverse[i] = 1'b0; last_round[i] = 1'b0;
            value[i] = '0; last_res[i] = '0;
        end

        // Reset state.
        reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("reset_vm", value_mixed[i], 128'h0);
            check("reset_succ", 128'(success[i]), 128'(1'b0));
            check("reset_busy", 128'(busy[i]), 128'(1'b0));
        end
        repeat (2) @(posedge clk);
        reset = 1'b1;

        // Known forward and inverse vectors on every configuration.
        run_op(0, 128'hdb135345_f20a225c_01010101_2d26314c, 1'b0, 1'b0, "fwd_c1");
        check("fwd_c1_const", value_mixed[0], 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8);
        for (int i = 0; i < 3; i++) begin
            run_op(i, 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8, 1'b1, 1'b0, "inv");
            check("inv_const", value_mixed[i], 128'hdb135345_f20a225c_01010101_2d26314c);
        end

        // Bypass, then the c6/d4 column pair in forward mode.
        run_op(0, 128'h00112233_44556677_8899aabb_ccddeeff, 1'b0, 1'b1, "bypass");
        check("bypass_const", value_mixed[0], 128'h00112233_44556677_8899aabb_ccddeeff);
        v = rnd128();
        v[127:64] = {32'hc6c6c6c6, 32'hd4d4d4d5};
        run_op(0, v, 1'b0, 1'b0, "c6d4");
        check("c6d4_const", value_mixed[0] >> 64, 128'(64'hc6c6c6c6_d5d5d7d6));

        // Randomized blocks on every configuration.
        for (int i = 0; i < 3; i++)
            for (int t = 0; t < 6; t++)
                run_op(i, rnd128(), 1'($urandom_range(1)), 1'($urandom_range(3) == 0), "rand");

        // Busy protection: mixEnable held high and value changing each cycle.
        a_blk = rnd128();
        b_blk = rnd128();
        succ_count = 0;
        @(posedge clk);
        mix_enable[0] = 1'b1; inverse[0] = 1'b0; last_round[0] = 1'b0; value[0] = a_blk;
        @(negedge clk);                                  // E0
        for (int e = 1; e <= 10; e++) begin
            @(negedge clk);                              // Ee
            @(posedge clk);
            if (success[0]) succ_count++;
            if (e < 4) begin
                check("busyp_busy_a", 128'(busy[0]), 128'(1'b1));
                value[0] = rnd128();
            end else if (e == 4) begin
                check("busyp_succ_a", 128'(success[0]), 128'(1'b1));
                check("busyp_res_a", value_mixed[0], ref_mix(a_blk, 1'b0, 1'b0));
                value[0] = b_blk;
            end else if (e == 5) begin
                check("busyp_accept_e5", 128'(busy[0]), 128'(1'b1));
                check("busyp_hold_a", value_mixed[0], ref_mix(a_blk, 1'b0, 1'b0));
                mix_enable[0] = 1'b0;
                value[0] = rnd128();
            end else if (e < 9) begin
                check("busyp_busy_b", 128'(busy[0]), 128'(1'b1));
                value[0] = rnd128();
            end else if (e == 9) begin
                check("busyp_succ_b", 128'(success[0]), 128'(1'b1));
                check("busyp_res_b", value_mixed[0], ref_mix(b_blk, 1'b0, 1'b0));
            end else begin
                check("busyp_idle", 128'(busy[0]), 128'(1'b0));
            end
        end
        check("busyp_pulses", 128'(succ_count), 128'(2));
        last_res[0] = ref_mix(b_blk, 1'b0, 1'b0);

        // Reset between E2 and E3 aborts the block.
        @(posedge clk);
        mix_enable[0] = 1'b1; inverse[0] = 1'b1; value[0] = rnd128();
        @(negedge clk);                                  // E0
        @(posedge clk);
        mix_enable[0] = 1'b0;
        @(negedge clk);                                  // E1
        @(negedge clk);                                  // E2
        @(posedge clk);
        reset = 1'b0;
        #1;
        check("rst_mid_vm", value_mixed[0], 128'h0);
        check("rst_mid_succ", 128'(success[0]), 128'(1'b0));
        check("rst_mid_busy", 128'(busy[0]), 128'(1'b0));
        for (int i = 0; i < 3; i++) last_res[i] = '0;
        @(negedge clk);                                  // would-be E3
        @(posedge clk);
        check("rst_mid_nosucc", 128'(success[0]), 128'(1'b0));
        reset = 1'b1;
        run_op(0, rnd128(), 1'b0, 1'b0, "after_rst");
        run_op(0, rnd128(), 1'b1, 1'b0, "after_rst_inv");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
